// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between a CPU port and a host loader port sharing one
// single-port data memory. Grant lasts one cycle, with registered read data one cycle later.
module dmem_arbiter #(
   parameter int AW = 10,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   output logic [7:0]    cpu_stall_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CPU  = 2'd1;
   localparam logic [1:0] HOST = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic          last_host;
   logic          cpu_cand;
   logic          host_cand;
   logic          acc_en;
   logic          acc_we;
   logic [AW-1:0] acc_addr;
   logic [DW-1:0] acc_wdata;
   logic [DW-1:0] mem [2**AW];

   assign cpu_gnt   = (state == CPU);
   assign host_gnt  = (state == HOST);
   assign acc_en    = cpu_gnt | host_gnt;
   assign acc_we    = host_gnt ? host_we    : cpu_we;
   assign acc_addr  = host_gnt ? host_addr  : cpu_addr;
   assign acc_wdata = host_gnt ? host_wdata : cpu_wdata;

   // The current owner is masked out, so a lone requester is granted at most every other cycle.
   always_comb begin
      cpu_cand   = cpu_req  && (state != CPU);
      host_cand  = host_req && (state != HOST);
      state_next = IDLE;
      if (cpu_cand && host_cand)
         state_next = last_host ? CPU : HOST;
      else if (cpu_cand)
         state_next = CPU;
      else if (host_cand)
         state_next = HOST;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_host <= 1'b1;
      end else begin
         state <= state_next;
         if (state == CPU)
            last_host <= 1'b0;
         else if (state == HOST)
            last_host <= 1'b1;
      end
   end

   // Memory array is deliberately left out of reset; a write in a reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (!rst && acc_en && acc_we)
         mem[acc_addr] <= acc_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         cpu_rdata   <= '0;
         host_rdata  <= '0;
      end else begin
         cpu_rvalid  <= cpu_gnt && !cpu_we;
         host_rvalid <= host_gnt && !host_we;
         if (cpu_gnt && !cpu_we)
            cpu_rdata <= mem[acc_addr];
         if (host_gnt && !host_we)
            host_rdata <= mem[acc_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         cpu_stall_cnt <= 8'd0;
      else if (cpu_req && !cpu_gnt && (cpu_stall_cnt != 8'hFF))
         cpu_stall_cnt <= cpu_stall_cnt + 8'd1;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_arbiter;
   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          host_req = 1'b0, host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
   logic [DW-1:0] cpu_rdata, host_rdata;
   logic [7:0]    cpu_stall_cnt;

   int errors = 0;
   int checks = 0;

   // Model: owner 0 = nobody, 1 = CPU, 2 = host; m_last is the most recent owner.
   int            m_owner = 0;
   int            m_last  = 2;
   logic [DW-1:0] m_mem [2**AW];
   bit            m_cpu_rv = 0, m_host_rv = 0;
   logic [DW-1:0] m_cpu_rd = '0, m_host_rd = '0;
   int            m_stall = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .cpu_stall_cnt(cpu_stall_cnt)
   );

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and update the model from the inputs seen at that edge.
   task automatic step();
      bit cw, hw;
      @(posedge clk);
      if (rst) begin
         m_owner = 0; m_last = 2; m_cpu_rv = 0; m_host_rv = 0;
         m_cpu_rd = '0; m_host_rd = '0; m_stall = 0;
      end else begin
         cw = cpu_req && (m_owner != 1);
         hw = host_req && (m_owner != 2);
         m_cpu_rv = 0; m_host_rv = 0;
         if (cpu_req && m_owner != 1 && m_stall < 255) m_stall++;
         if (m_owner == 1) begin
            if (cpu_we) m_mem[cpu_addr] = cpu_wdata;
            else begin m_cpu_rv = 1; m_cpu_rd = m_mem[cpu_addr]; end
            m_last = 1;
         end else if (m_owner == 2) begin
            if (host_we) m_mem[host_addr] = host_wdata;
            else begin m_host_rv = 1; m_host_rd = m_mem[host_addr]; end
            m_last = 2;
         end
         if (cw && hw) m_owner = (m_last == 1) ? 2 : 1;
         else if (cw) m_owner = 1;
         else if (hw) m_owner = 2;
         else m_owner = 0;
      end
      #1;
   endtask

   // Drive one access on the chosen port, wait for its grant and finish its access edge.
   task automatic access(input bit host, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      int want = host ? 2 : 1;
      if (host) begin host_req = 1; host_we = we; host_addr = a; host_wdata = d; end
      else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
      do begin
         step(); n++;
         checks++;
         if ({cpu_gnt, host_gnt} !== {m_owner == 1, m_owner == 2}) begin
            errors++;
            $display("[TB] FAIL access_gnt: got cpu=%0b host=%0b want cpu=%0b host=%0b",
                     cpu_gnt, host_gnt, m_owner == 1, m_owner == 2);
         end
      end while (m_owner != want && n < 8);
      if (m_owner != want) begin
         errors++;
         $display("[TB] FAIL access_timeout: no grant after %0d cycles, want owner %0d", n, want);
      end
      step();
      if (host) host_req = 0; else cpu_req = 0;
   endtask

   // Release each requester right after its own grant cycle.
   task automatic drain();
      int owner_before;
      for (int k = 0; k < 6 && (cpu_req || host_req); k++) begin
         owner_before = m_owner;
         step();
         if (owner_before == 1) cpu_req = 0;
         if (owner_before == 2) host_req = 0;
      end
      step(); step();
   endtask

   task automatic test_reset();
      rst = 1;
      step(); step();
      checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_gnt: got %0b want 0", cpu_gnt); end
      checks++; if (host_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_host_gnt: got %0b want 0", host_gnt); end
      checks++; if ({cpu_rvalid, host_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 00", {cpu_rvalid, host_rvalid}); end
      checks++; if ({cpu_rdata, host_rdata} !== '0) begin errors++; $display("[TB] FAIL reset_rdata: got %h %h want 0 0", cpu_rdata, host_rdata); end
      checks++; if (cpu_stall_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_stall: got %0d want 0", cpu_stall_cnt); end
      rst = 0;
      step();
   endtask

   task automatic test_fill();
      for (int a = 0; a < 16; a++) begin
         access(a[0], 1'b1, AW'(a), DW'($urandom));
         step();
      end
   endtask

   task automatic test_cpu_rw();
      cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wdata = 16'h1234;
      step();
      checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rw_write_gnt: got %0b want 1", cpu_gnt); end
      step();
      cpu_req = 1; cpu_we = 0; cpu_addr = 5;
      checks++; if ({cpu_gnt, cpu_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL rw_after_write: got gnt=%0b rvalid=%0b want 0 0", cpu_gnt, cpu_rvalid); end
      step();
      checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rw_read_gnt: got %0b want 1", cpu_gnt); end
      cpu_req = 0;
      step();
      checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rw_rvalid: got %0b want 1", cpu_rvalid); end
      checks++; if (cpu_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL rw_rdata: got %h want 1234", cpu_rdata); end
      step();
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rw_rvalid_pulse: got %0b want 0", cpu_rvalid); end
      checks++; if (cpu_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL rw_rdata_hold: got %h want 1234", cpu_rdata); end
   endtask

   task automatic test_both();
      rst = 1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 1;
      host_req = 1; host_we = 0; host_addr = 3;
      step();
      rst = 0;
      checks++; if ({cpu_gnt, host_gnt} !== 2'b00) begin errors++; $display("[TB] FAIL both_release: got %b want 00", {cpu_gnt, host_gnt}); end
      for (int i = 1; i <= 8; i++) begin
         step();
         checks++;
         if ({cpu_gnt, host_gnt} !== {i % 2 == 1, i % 2 == 0}) begin
            errors++;
            $display("[TB] FAIL both_alternate cycle %0d: got cpu=%0b host=%0b want cpu=%0b host=%0b",
                     i, cpu_gnt, host_gnt, i % 2 == 1, i % 2 == 0);
         end
         checks++;
         if (host_rvalid !== (i % 2 == 1 && i >= 3)) begin
            errors++; $display("[TB] FAIL both_host_rvalid cycle %0d: got %0b want %0b", i, host_rvalid, i % 2 == 1 && i >= 3);
         end
         if (i >= 3 && i % 2 == 1) begin
            checks++;
            if (host_rdata !== m_mem[3]) begin errors++; $display("[TB] FAIL both_host_rdata: got %h want %h", host_rdata, m_mem[3]); end
         end
      end
      drain();
   endtask

   task automatic test_host_alone();
      host_req = 1; host_we = 1; host_addr = 9; host_wdata = 16'h9000;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({host_gnt, cpu_gnt} !== {i % 2 == 1, 1'b0}) begin
            errors++; $display("[TB] FAIL host_alone_pattern cycle %0d: got host=%0b cpu=%0b want host=%0b cpu=0",
                               i, host_gnt, cpu_gnt, i % 2 == 1);
         end
         step();
         if (i % 2 == 1) host_wdata = 16'h9000 + 16'(i);
      end
      host_req = 0;
      step();
      access(1'b0, 1'b0, 10'd9, '0);
      checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL host_alone_rvalid: got %0b want 1", cpu_rvalid); end
      checks++; if (cpu_rdata !== 16'h9003) begin errors++; $display("[TB] FAIL host_alone_data: got %h want 9003", cpu_rdata); end
      step();
   endtask

   task automatic test_stall_sat();
      logic [7:0] prev = '0;
      rst = 1; step(); rst = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 2;
      host_req = 1; host_we = 0; host_addr = 4;
      for (int i = 0; i < 700; i++) begin
         step();
         checks++;
         if (cpu_stall_cnt !== 8'(m_stall)) begin errors++; $display("[TB] FAIL stall_count cycle %0d: got %0d want %0d", i, cpu_stall_cnt, m_stall); end
         checks++;
         if (cpu_stall_cnt < prev) begin errors++; $display("[TB] FAIL stall_wrap cycle %0d: got %0d after %0d", i, cpu_stall_cnt, prev); end
         prev = cpu_stall_cnt;
      end
      checks++; if (cpu_stall_cnt !== 8'd255) begin errors++; $display("[TB] FAIL stall_saturate: got %0d want 255", cpu_stall_cnt); end
      drain();
   endtask

   task automatic test_reset_grant();
      access(1'b0, 1'b1, 10'd7, 16'hAAAA);
      step();
      host_req = 1; host_we = 1; host_addr = 7; host_wdata = 16'h5555;
      step();
      checks++; if (host_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rstgnt_host_gnt: got %0b want 1", host_gnt); end
      rst = 1;
      step();
      rst = 0; host_req = 0;
      checks++;
      if ({cpu_gnt, host_gnt, cpu_rvalid, host_rvalid} !== 4'b0000 || cpu_rdata !== '0 ||
          host_rdata !== '0 || cpu_stall_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL rstgnt_outputs: got gnt=%b%b rv=%b%b rd=%h/%h stall=%0d want all zero",
                  cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata, cpu_stall_cnt);
      end
      step();
      checks++; if (host_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstgnt_no_rvalid: got %0b want 0", host_rvalid); end
      access(1'b0, 1'b0, 10'd7, '0);
      checks++; if (cpu_rdata !== 16'hAAAA) begin errors++; $display("[TB] FAIL rstgnt_mem: got %h want aaaa", cpu_rdata); end
      step();
   endtask

   task automatic test_withdraw();
      logic [DW-1:0] old10;
      old10 = m_mem[10];
      host_req = 1; host_we = 1; host_addr = 8; host_wdata = 16'h0808;
      cpu_req = 1; cpu_we = 1; cpu_addr = 10; cpu_wdata = 16'hBEEF;
      step();
      checks++; if ({host_gnt, cpu_gnt} !== 2'b10) begin errors++; $display("[TB] FAIL withdraw_host_first: got host=%0b cpu=%0b want 1 0", host_gnt, cpu_gnt); end
      cpu_req = 0;
      step();
      host_req = 0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({cpu_gnt, cpu_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL withdraw_cpu_idle cycle %0d: got gnt=%0b rvalid=%0b want 0 0", i, cpu_gnt, cpu_rvalid); end
         step();
      end
      access(1'b1, 1'b0, 10'd10, '0);
      checks++; if (host_rdata !== old10) begin errors++; $display("[TB] FAIL withdraw_mem: got %h want %h", host_rdata, old10); end
      step();
   endtask

   task automatic test_random();
      bit was_cpu, was_host;
      for (int i = 0; i < 500; i++) begin
         was_cpu = (m_owner == 1); was_host = (m_owner == 2);
         step();
         checks++;
         if ({cpu_gnt, host_gnt} !== {m_owner == 1, m_owner == 2} || (cpu_gnt && host_gnt)) begin
            errors++; $display("[TB] FAIL rand_gnt cycle %0d: got cpu=%0b host=%0b want cpu=%0b host=%0b",
                               i, cpu_gnt, host_gnt, m_owner == 1, m_owner == 2);
         end
         checks++;
         if ({cpu_rvalid, host_rvalid} !== {m_cpu_rv, m_host_rv}) begin
            errors++; $display("[TB] FAIL rand_rvalid cycle %0d: got %b%b want %b%b", i, cpu_rvalid, host_rvalid, m_cpu_rv, m_host_rv);
         end
         checks++;
         if (cpu_rdata !== m_cpu_rd || host_rdata !== m_host_rd) begin
            errors++; $display("[TB] FAIL rand_rdata cycle %0d: got %h/%h want %h/%h", i, cpu_rdata, host_rdata, m_cpu_rd, m_host_rd);
         end
         checks++;
         if (cpu_stall_cnt !== 8'(m_stall)) begin errors++; $display("[TB] FAIL rand_stall cycle %0d: got %0d want %0d", i, cpu_stall_cnt, m_stall); end
         if (m_owner != 1 && (was_cpu || !cpu_req || $urandom_range(0, 7) == 0)) begin
            cpu_req = ($urandom_range(0, 2) != 0); cpu_we = $urandom_range(0, 1) == 1;
            cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = DW'($urandom);
         end
         if (m_owner != 2 && (was_host || !host_req || $urandom_range(0, 7) == 0)) begin
            host_req = ($urandom_range(0, 2) != 0); host_we = $urandom_range(0, 1) == 1;
            host_addr = AW'($urandom_range(0, 15)); host_wdata = DW'($urandom);
         end
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_cpu_rw();
      test_both();
      test_host_alone();
      test_stall_sat();
      test_reset_grant();
      test_withdraw();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
